// File: rtl/bus_pkg.sv
// Shared bus types used by the bus interfaces and the slaves hanging off them.
// Also carries the SRAM slave's FSM state type so benches can observe it.
package bus_pkg;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } tsize_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } slave_state_e;

    localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/sram_array.sv
// Byte-enabled word storage: one write port with per-lane enables and one
// synchronous read port. Contents are deliberately not reset.
module sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bus_sram_slave.sv
// Single-outstanding bus slave in front of a byte-enabled SRAM, with a
// programmable number of wait states before the one-cycle bdone response.
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic         bclk,
    input  logic         brst_n,
    input  logic         ss,
    input  logic         bstart,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    input  tsize_e       tsize,
    input  ttype_e       bwrite,
    output logic [31:0]  rdata,
    output logic         bdone,
    output logic         berror,
    output slave_state_e dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Handshake: a request is taken only in IDLE on a rising edge with
    // ss=1 and bstart=1; bdone pulses for exactly one cycle WAIT_STATES+1
    // cycles later, berror qualifies that pulse, and bstart seen at any
    // other time is dropped rather than queued.

    slave_state_e state_q, state_d;
    logic [3:0]    cnt_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    tsize_e        tsize_q;
    ttype_e        bwrite_q;
    logic [31:0]   rdata_q;

    logic          accept;
    logic          misaligned;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_steer;
    logic [31:0]   resp_rdata;
    logic          sram_we;
    logic [AW-1:0] sram_raddr;
    logic          unused_addr_bits;

    assign accept = ss && bstart;
    assign unused_addr_bits = ^addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tsize_q  <= BYTE;
            bwrite_q <= READ;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && accept) begin
                cnt_q    <= 4'(WAIT_STATES);
                addr_q   <= addr[AW+1:0];
                wdata_q  <= wdata;
                tsize_q  <= tsize;
                bwrite_q <= bwrite;
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == RESP) begin
                rdata_q <= resp_rdata;
            end
        end
    end

    // Undefined tsize encodings are treated as misaligned.
    always_comb begin
        misaligned = 1'b0;
        case (tsize_q)
            BYTE:     misaligned = 1'b0;
            HALFWORD: misaligned = addr_q[0];
            WORD:     misaligned = |addr_q[1:0];
            default:  misaligned = 1'b1;
        endcase
    end

    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = wdata_q;
        rd_shift = rd_word;
        rd_steer = rd_word;
        case (tsize_q)
            BYTE: begin
                byte_en  = 4'b0001 << addr_q[1:0];
                wr_lanes = {4{wdata_q[7:0]}};
                rd_shift = rd_word >> {addr_q[1:0], 3'b000};
                rd_steer = {24'h0, rd_shift[7:0]};
            end
            HALFWORD: begin
                byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
                rd_shift = rd_word >> {addr_q[1], 4'b0000};
                rd_steer = {16'h0, rd_shift[15:0]};
            end
            WORD: begin
                byte_en  = 4'b1111;
                wr_lanes = wdata_q;
                rd_steer = rd_word;
            end
            default: begin
                byte_en  = 4'b0000;
                rd_steer = 32'h0;
            end
        endcase
    end

    // Writes leave the held read value alone; any error response zeroes it.
    always_comb begin
        if (misaligned) begin
            resp_rdata = 32'h0;
        end else if (bwrite_q == WRITE) begin
            resp_rdata = rdata_q;
        end else begin
            resp_rdata = rd_steer;
        end
    end

    // The synchronous read is issued on the edge entering RESP, so the read
    // address follows the live bus while idle (covers WAIT_STATES=0).
    assign sram_raddr = (state_q == IDLE) ? addr[AW+1:2] : addr_q[AW+1:2];
    assign sram_we    = (state_q == RESP) && (bwrite_q == WRITE) && !misaligned;

    sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram_array (
        .clk   (bclk),
        .we    (sram_we),
        .be    (byte_en),
        .waddr (addr_q[AW+1:2]),
        .wdata (wr_lanes),
        .raddr (sram_raddr),
        .rdata (rd_word)
    );

    assign bdone     = (state_q == RESP);
    assign berror    = bdone && misaligned;
    assign rdata     = (state_q == RESP) ? resp_rdata : rdata_q;
    assign dbg_state = state_q;

endmodule
